kamus_lsu_ctrl: RTL and testbench
=================================

// Module: kamus_lsu_ctrl
// PURPOSE
// - Sequences every load/store from the MEM stage onto the L1D port (req/gnt, rvalid), one access in flight.
// - Generates byte enables, lane-aligned write data and sign/zero-extended load data; stalls IF..MEM until done.
// - Sits between kamus_MEM and the L1 data cache; a timeout guards against a dead memory.
// PARAMETERS
// - TIMEOUT_CYC  256  cycles in REQ+WAIT before the access is aborted with err_o (>=2)
// - CNT_W        $clog2(TIMEOUT_CYC)  timeout counter width (derived, do not override)
// PORTS
// - clk_i          in   1   core clock
// - rst_ni         in   1   reset, asynchronous, active-low
// - mem_req_i      in   1   MEM stage holds a load/store; held stable while stall_o=1
// - mem_we_i       in   1   1=store, 0=load
// - mem_size_i     in   2   00=byte 01=half 10=word (11 treated as word)
// - mem_unsigned_i in   1   load zero-extends (LBU/LHU)
// - mem_addr_i     in   32  byte address (EX result)
// - mem_wdata_i    in   32  rs2 value, unshifted
// - mem_rdata_o    out  32  extended load data, valid while mem_done_o=1
// - mem_done_o     out  1   one-cycle completion pulse
// - stall_o        out  1   freeze IF..MEM pipeline registers
// - err_o          out  1   one-cycle pulse with mem_done_o: timeout abort
// - misalign_o     out  1   one-cycle pulse with mem_done_o: misaligned access (macro only, else 0)
// - l1d_req_o      out  1   request, held until l1d_gnt_i
// - l1d_gnt_i      in   1   request accepted this cycle
// - l1d_we_o       out  1   write enable
// - l1d_be_o       out  4   byte enables
// - l1d_addr_o     out  32  word address ({addr[31:2],2'b00})
// - l1d_wdata_o    out  32  lane-replicated write data
// - l1d_rvalid_i   in   1   read data / write ack valid
// - l1d_rdata_i    in   32  read word
// BEHAVIOUR
// - Reset (async, rst_ni=0): state IDLE, counter 0, all captured regs 0; all outputs 0; takes effect mid-access, no pulse.
// - FSM IDLE->REQ->WAIT->DONE->IDLE.
//   IDLE: mem_req_i=1 captures addr/size/unsigned/we/wdata, goes REQ; stall_o=mem_req_i (comb).
//   REQ: l1d_req_o=1; gnt&rvalid same cycle -> DONE; gnt only -> WAIT; rvalid without gnt ignored.
//   WAIT: l1d_req_o=0; rvalid -> DONE.
//   DONE: mem_done_o=1, stall_o=0, mem_req_i ignored (same instr); next state IDLE.
// - stall_o=1 in REQ and WAIT; min latency req->done = 2 cycles (IDLE cycle N, REQ N+1, DONE N+2).
// - Timeout: counter clears on IDLE->REQ, increments in REQ/WAIT; at TIMEOUT_CYC-1 without completion -> DONE, err_o=1,
//   mem_rdata_o=0, l1d_req_o dropped; later stray rvalid ignored.
// - l1d_addr_o/be_o/we_o/wdata_o driven from captured regs in REQ (stable until gnt); 0 elsewhere.
// - BE: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
// - WDATA: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
// - Load: sh = l1d_rdata_i >> (8*a[1:0]) captured on rvalid; byte -> ext of sh[7:0], half -> ext of sh[15:0],
//   word -> sh; ext = sign unless mem_unsigned_i. Stores: mem_rdata_o=0.
// - Misaligned: half with a[0]=1, word with a[1:0]!=0.
// CONFIGURATION
// - KAMUS_LSU_MISALIGN_TRAP_EN defined: misaligned access issues no L1D request; IDLE->DONE directly,
//   mem_done_o=1 and misalign_o=1 together one cycle after capture, mem_rdata_o=0.
// - Undefined: misalign_o tied 0; low address bits forced (half a[0]=0, word a[1:0]=0) before BE/extraction.
// TESTING
// - Load byte signed, addr 0x1003, rdata 0x80AA_BBCC, gnt+rvalid in REQ -> be=4'b1000, addr=0x1000, rdata_o=0xFFFF_FF80, done at N+2.
// - LHU addr 0x2002, rdata 0x8123_4567, gnt N+1, rvalid N+4 -> be=4'b1100, rdata_o=0x0000_8123, stall_o 1 N..N+4, done N+5.
// - SB addr 0x3001, wdata 0x1234_56AB, gnt held low 3 cycles -> l1d_req_o/addr/wdata=0xABAB_ABAB/be=4'b0010 stable until gnt.
// - No gnt, TIMEOUT_CYC=8 -> err_o+mem_done_o pulse, rdata_o=0, return IDLE; later rvalid ignored.
// - LW addr 0x4002: with macro -> misalign_o+done one cycle after capture, l1d_req_o never 1; without -> l1d_addr_o=0x4000, be=4'b1111.
// - rst_ni low while in WAIT -> all outputs 0 immediately; after release, new LW completes normally with no stale done pulse.

Source files
------------

// File: rtl/kamus_lsu_ctrl.sv
// kamus_lsu_ctrl: load/store sequencer between the MEM stage and the L1 data cache.
// Keeps one access in flight over a req/gnt + rvalid port. It builds byte enables and
// lane-replicated store data, and returns sign- or zero-extended load data.
// A timeout counter aborts an access when memory never answers.
// Optional feature macro: KAMUS_LSU_MISALIGN_TRAP_EN.
//   Defined:   a misaligned access completes at once with misalign_o and never reaches L1D.
//   Undefined: the low address bits are forced to the natural alignment of the access size.
module kamus_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        l1d_req_o,
  input  logic        l1d_gnt_i,
  output logic        l1d_we_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_addr_o,
  output logic [31:0] l1d_wdata_o,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
  logic             mis_q;
  logic             mis_in_s;
`endif

  logic [1:0]  lo_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [31:0] sh_s;
  logic [31:0] ld_s;

  // Effective low address bits used for lane selection (forced alignment when not trapping)
  always_comb begin
    lo_s = addr_q[1:0];
`ifndef KAMUS_LSU_MISALIGN_TRAP_EN
    if (size_q == 2'b00) begin
      lo_s = addr_q[1:0];
    end else if (size_q == 2'b01) begin
      lo_s = {addr_q[1], 1'b0};
    end else begin
      lo_s = 2'b00;
    end
`endif
  end

`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
  // Misalignment of the incoming request, judged at capture time
  always_comb begin
    mis_in_s = 1'b0;
    case (mem_size_i)
      2'b00:   mis_in_s = 1'b0;
      2'b01:   mis_in_s = mem_addr_i[0];
      default: mis_in_s = (mem_addr_i[1:0] != 2'b00);
    endcase
  end
`endif

  // Byte enables, replicated store data and extended load data for the captured access
  always_comb begin
    be_s = 4'b0000;
    wd_s = 32'h0000_0000;
    ld_s = 32'h0000_0000;
    sh_s = l1d_rdata_i >> {lo_s, 3'b000};
    case (size_q)
      2'b00: begin
        be_s = 4'b0001 << lo_s;
        wd_s = {4{wdata_q[7:0]}};
        ld_s = uns_q ? {24'h00_0000, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
      end
      2'b01: begin
        be_s = 4'b0011 << {lo_s[1], 1'b0};
        wd_s = {2{wdata_q[15:0]}};
        ld_s = uns_q ? {16'h0000, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
      end
      default: begin
        be_s = 4'b1111;
        wd_s = wdata_q;
        ld_s = sh_s;
      end
    endcase
    if (we_q) begin
      ld_s = 32'h0000_0000;
    end else begin
      ld_s = ld_s;
    end
  end

  // Access sequencer: capture, request, wait for data, one-cycle completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            we_q    <= mem_we_i;
            wdata_q <= mem_wdata_i;
            cnt_q   <= '0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_in_s;
            state_q <= mis_in_s ? S_DONE : S_REQ;
`else
            state_q <= S_REQ;
`endif
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (l1d_gnt_i && l1d_rvalid_i) begin
            rdata_q <= ld_s;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (l1d_gnt_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (l1d_rvalid_i) begin
            rdata_q <= ld_s;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          rdata_q <= 32'h0000_0000;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
          mis_q   <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from the state and captured registers
  always_comb begin
    l1d_req_o   = 1'b0;
    l1d_we_o    = 1'b0;
    l1d_be_o    = 4'b0000;
    l1d_addr_o  = 32'h0000_0000;
    l1d_wdata_o = 32'h0000_0000;
    mem_done_o  = 1'b0;
    mem_rdata_o = 32'h0000_0000;
    err_o       = 1'b0;
    misalign_o  = 1'b0;
    stall_o     = 1'b0;
    case (state_q)
      S_IDLE: stall_o = rst_ni & mem_req_i;
      S_REQ: begin
        stall_o     = 1'b1;
        l1d_req_o   = 1'b1;
        l1d_we_o    = we_q;
        l1d_be_o    = be_s;
        l1d_addr_o  = {addr_q[31:2], 2'b00};
        l1d_wdata_o = wd_s;
      end
      S_WAIT: stall_o = 1'b1;
      S_DONE: begin
        mem_done_o  = 1'b1;
        mem_rdata_o = rdata_q;
        err_o       = err_q;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
        misalign_o  = mis_q;
`else
        misalign_o  = 1'b0;
`endif
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Self-checking bench for kamus_lsu_ctrl (TIMEOUT_CYC=8); completions checked through a scoreboard.
module tb_kamus_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_we, mem_uns;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, stall, err, misalign;
  logic        l1d_req, l1d_gnt, l1d_we, l1d_rvalid;
  logic [3:0]  l1d_be;
  logic [31:0] l1d_addr, l1d_wdata, l1d_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  kamus_lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_unsigned_i(mem_uns), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done), .stall_o(stall),
    .err_o(err), .misalign_o(misalign),
    .l1d_req_o(l1d_req), .l1d_gnt_i(l1d_gnt), .l1d_we_o(l1d_we), .l1d_be_o(l1d_be),
    .l1d_addr_o(l1d_addr), .l1d_wdata_o(l1d_wdata),
    .l1d_rvalid_i(l1d_rvalid), .l1d_rdata_i(l1d_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every completion pulse is matched against the oldest expected result
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && mem_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done rdata=%h err=%b mis=%b", mem_rdata, err, misalign);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_rdata, err, misalign} !== {mon_e.rdata, mon_e.err, mon_e.mis}) begin
          failures++;
          $display("FAIL sb_done got rdata=%h err=%b mis=%b want rdata=%h err=%b mis=%b",
                   mem_rdata, err, misalign, mon_e.rdata, mon_e.err, mon_e.mis);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_uns = uns;
    mem_addr = a; mem_wdata = wd;
  endtask

  task automatic quiet();
    mem_req = 1'b0; l1d_gnt = 1'b0; l1d_rvalid = 1'b0; l1d_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet();
    issue(1'b1, 2'b10, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    #3;
    checks++;
    if ({mem_done, stall, err, misalign, l1d_req, l1d_we} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000", {mem_done, stall, err, misalign, l1d_req, l1d_we});
    end
    checks++;
    if ({mem_rdata, l1d_addr, l1d_wdata, l1d_be} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b want all 0", mem_rdata, l1d_addr, l1d_wdata, l1d_be);
    end
    @(negedge clk);
    quiet();
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    @(negedge clk);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    exp_q.push_back('{32'hFFFF_FF80, 1'b0, 1'b0});
    #1;
    checks++;
    if ({stall, l1d_req} !== 2'b10) begin
      failures++; $display("FAIL lb_idle stall/req=%b want 10", {stall, l1d_req});
    end
    @(negedge clk); #1;
    checks++;
    if ({l1d_req, l1d_we, l1d_be, l1d_addr} !== {1'b1, 1'b0, 4'b1000, 32'h0000_1000}) begin
      failures++;
      $display("FAIL lb_req req=%b we=%b be=%b addr=%h want 1 0 1000 00001000", l1d_req, l1d_we, l1d_be, l1d_addr);
    end
    l1d_gnt = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'h80AA_BBCC;
    @(negedge clk);
    quiet(); #1;
    checks++;
    if ({mem_done, stall, l1d_req} !== 3'b100) begin
      failures++; $display("FAIL lb_done done/stall/req=%b want 100", {mem_done, stall, l1d_req});
    end
  endtask

  task automatic test_lhu_wait();
    @(negedge clk);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
    exp_q.push_back('{32'h0000_8123, 1'b0, 1'b0});
    @(negedge clk); #1;
    checks++;
    if ({l1d_req, l1d_be, l1d_addr, stall} !== {1'b1, 4'b1100, 32'h0000_2000, 1'b1}) begin
      failures++; $display("FAIL lhu_req req=%b be=%b addr=%h stall=%b", l1d_req, l1d_be, l1d_addr, stall);
    end
    l1d_gnt = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      l1d_gnt = 1'b0;
      if (i == 4) begin
        l1d_rvalid = 1'b1; l1d_rdata = 32'h8123_4567;
      end
      #1;
      checks++;
      if ({stall, l1d_req, mem_done} !== 3'b100) begin
        failures++; $display("FAIL lhu_wait_c%0d stall/req/done=%b want 100", i, {stall, l1d_req, mem_done});
      end
    end
    @(negedge clk);
    quiet(); #1;
    checks++;
    if ({mem_done, stall} !== 2'b10) begin
      failures++; $display("FAIL lhu_done done/stall=%b want 10", {mem_done, stall});
    end
  endtask

  task automatic test_sb_hold();
    @(negedge clk);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56AB);
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({l1d_req, l1d_we, l1d_be, l1d_addr, l1d_wdata} !==
          {1'b1, 1'b1, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB}) begin
        failures++;
        $display("FAIL sb_hold_c%0d req=%b we=%b be=%b addr=%h wdata=%h", i, l1d_req, l1d_we, l1d_be, l1d_addr, l1d_wdata);
      end
      if (i == 4) l1d_gnt = 1'b1;
    end
    @(negedge clk);
    l1d_gnt = 1'b0; l1d_rvalid = 1'b1; #1;
    checks++;
    if ({l1d_req, l1d_be, l1d_wdata} !== {1'b0, 4'b0000, 32'h0}) begin
      failures++; $display("FAIL sb_wait req=%b be=%b wdata=%h want 0", l1d_req, l1d_be, l1d_wdata);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      if ({l1d_req, stall, mem_done} !== 3'b110) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL to_req_held got=%b want req held 8 cycles", bad);
    end
    @(negedge clk);
    mem_req = 1'b0; #1;
    checks++;
    if ({mem_done, err, l1d_req, mem_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL to_done done=%b err=%b req=%b rdata=%h want 1 1 0 0", mem_done, err, l1d_req, mem_rdata);
    end
    @(negedge clk);
    l1d_rvalid = 1'b1; l1d_rdata = 32'h5555_AAAA;
    @(negedge clk);
    l1d_rvalid = 1'b0; #1;
    checks++;
    if ({mem_done, err, stall, l1d_req} !== 4'b0000) begin
      failures++; $display("FAIL to_stray done/err/stall/req=%b want 0000", {mem_done, err, stall, l1d_req});
    end
  endtask

  task automatic test_misalign();
    logic seen_req;
    seen_req = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0);
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    #1;
    if (l1d_req !== 1'b0) seen_req = 1'b1;
    @(negedge clk);
    mem_req = 1'b0; #1;
    if (l1d_req !== 1'b0) seen_req = 1'b1;
    checks++;
    if ({mem_done, misalign, seen_req} !== 3'b110) begin
      failures++; $display("FAIL mis_trap done/mis/req_seen=%b want 110", {mem_done, misalign, seen_req});
    end
    @(negedge clk); #1;
`else
    exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
    @(negedge clk); #1;
    checks++;
    if ({l1d_req, l1d_be, l1d_addr} !== {1'b1, 4'b1111, 32'h0000_4000}) begin
      failures++; $display("FAIL mis_force req=%b be=%b addr=%h want 1 1111 00004000", l1d_req, l1d_be, l1d_addr);
    end
    l1d_gnt = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    quiet(); #1;
    if (misalign !== 1'b0) seen_req = 1'b1;
    checks++;
    if ({mem_done, seen_req} !== 2'b10) begin
      failures++; $display("FAIL mis_noflag done/mis=%b want 10", {mem_done, seen_req});
    end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0);
    exp_q.push_back('{32'hFFFF_9ABC, 1'b0, 1'b0});
    @(negedge clk); #1;
    l1d_gnt = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'h9ABC_1234;
    @(negedge clk);
    l1d_gnt = 1'b0; l1d_rvalid = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hCAFE_F00D);
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    #1;
    checks++;
    if ({mem_done, stall} !== 2'b10) begin
      failures++; $display("FAIL b2b_done done/stall=%b want 10", {mem_done, stall});
    end
    @(negedge clk); #1;
    checks++;
    if ({l1d_req, stall, mem_done} !== 3'b010) begin
      failures++; $display("FAIL b2b_idle req/stall/done=%b want 010", {l1d_req, stall, mem_done});
    end
    @(negedge clk); #1;
    checks++;
    if ({l1d_req, l1d_we, l1d_be, l1d_wdata} !== {1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL b2b_sw req=%b we=%b be=%b wdata=%h", l1d_req, l1d_we, l1d_be, l1d_wdata);
    end
    l1d_gnt = 1'b1; l1d_rvalid = 1'b1;
    @(negedge clk);
    quiet();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0);
    @(negedge clk); #1;
    l1d_gnt = 1'b1;
    @(negedge clk);
    l1d_gnt = 1'b0; #1;
    rst_n = 1'b0; #1;
    checks++;
    if ({mem_done, stall, err, misalign, l1d_req, l1d_we, l1d_be, l1d_addr, mem_rdata} !== 74'h0) begin
      failures++; $display("FAIL rstmid_outputs done=%b stall=%b req=%b addr=%h want all 0", mem_done, stall, l1d_req, l1d_addr);
    end
    mem_req = 1'b0;
    l1d_rvalid = 1'b1; l1d_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    l1d_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({mem_done, stall, l1d_req} !== 3'b000) begin
      failures++; $display("FAIL rstmid_stale done/stall/req=%b want 000", {mem_done, stall, l1d_req});
    end
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8004, 32'h0);
    exp_q.push_back('{32'h1122_3344, 1'b0, 1'b0});
    @(negedge clk); #1;
    l1d_gnt = 1'b1; l1d_rvalid = 1'b1; l1d_rdata = 32'h1122_3344;
    @(negedge clk);
    quiet(); #1;
    checks++;
    if (mem_done !== 1'b1) begin
      failures++; $display("FAIL rstmid_new_lw done=%b want 1", mem_done);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_lhu_wait();
    test_sb_hold();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
